// File: rtl/timeout_supervisor.sv
// Request/acknowledge supervisor: times each request attempt with an up-counter,
// retries a bounded number of times and latches a sticky fault when all attempts expire.
module timeout_supervisor #(
   parameter int WIDTH     = 16,
   parameter int RETRY_W   = 3,
   parameter int MAX_RETRY = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               ack_i,
   output logic               req_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               timeout_o,
   output logic               fault_o,
   output logic [RETRY_W-1:0] retry_cnt_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      GAP   = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [RETRY_W-1:0] LastRetry = RETRY_W'(MAX_RETRY);

   state_t           state;
   logic [WIDTH-1:0] cnt;

   // Single FSM register; every output is set alongside the state transition that implies it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         retry_cnt_o <= '0;
         req_o       <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         timeout_o   <= 1'b0;
         fault_o     <= 1'b0;
      end else begin
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state       <= REQ;
                  cnt         <= '0;
                  retry_cnt_o <= '0;
                  req_o       <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end
            REQ: begin
               // Acknowledge takes priority over a timeout landing on the same edge.
               if (ack_i) begin
                  state  <= IDLE;
                  req_o  <= 1'b0;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end else if (cnt == '1) begin
                  timeout_o <= 1'b1;
                  req_o     <= 1'b0;
                  cnt       <= '0;
                  if (retry_cnt_o == LastRetry) begin
                     state   <= FAULT;
                     fault_o <= 1'b1;
                     busy_o  <= 1'b0;
                  end else begin
                     state       <= GAP;
                     retry_cnt_o <= retry_cnt_o + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               state <= REQ;
               cnt   <= '0;
               req_o <= 1'b1;
            end
            FAULT: begin
               if (start_i) begin
                  state       <= REQ;
                  fault_o     <= 1'b0;
                  cnt         <= '0;
                  retry_cnt_o <= '0;
                  req_o       <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               req_o  <= 1'b0;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timeout_supervisor.sv
// Directed bench for timeout_supervisor with WIDTH=4, MAX_RETRY=2: reset, acknowledge,
// full timeout to fault, boundary acknowledge, ignored inputs and mid-request reset.
module tb_timeout_supervisor;

   localparam int WIDTH     = 4;
   localparam int RETRY_W   = 3;
   localparam int MAX_RETRY = 2;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               start_i;
   logic               ack_i;
   logic               req_o;
   logic               busy_o;
   logic               done_o;
   logic               timeout_o;
   logic               fault_o;
   logic [RETRY_W-1:0] retry_cnt_o;

   int errors = 0;
   int checks = 0;

   timeout_supervisor #(
      .WIDTH(WIDTH),
      .RETRY_W(RETRY_W),
      .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .start_i(start_i),
      .ack_i(ack_i),
      .req_o(req_o),
      .busy_o(busy_o),
      .done_o(done_o),
      .timeout_o(timeout_o),
      .fault_o(fault_o),
      .retry_cnt_o(retry_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic applyStimulus(input logic startVal, input logic ackVal);
      start_i = startVal;
      ack_i   = ackVal;
   endtask

   // Advance past the next rising edge; outputs then reflect that edge.
   task automatic stepCycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int reqCycles;
      int timeouts;
      int faultAt;
      int bothCount;
      int doneEarly;
      logic reqHist [0:70];
      logic toHist  [0:70];

      // Reset with arbitrary inputs
      rst_i = 1'b1;
      applyStimulus(1'b1, 1'b1);
      #3;
      checkOutput("reset_req", req_o, 1'b0);
      checkOutput("reset_busy", busy_o, 1'b0);
      checkOutput("reset_done", done_o, 1'b0);
      checkOutput("reset_timeout", timeout_o, 1'b0);
      checkOutput("reset_fault", fault_o, 1'b0);
      checkOutput("reset_retry", retry_cnt_o, 0);
      stepCycle();
      stepCycle();
      checkOutput("reset_held_req", req_o, 1'b0);
      applyStimulus(1'b0, 1'b0);
      rst_i = 1'b0;
      repeat (3) stepCycle();
      checkOutput("idle_req", req_o, 1'b0);
      checkOutput("idle_busy", busy_o, 1'b0);

      // Normal acknowledge on the 5th request cycle
      applyStimulus(1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0);
      reqCycles = 0;
      for (int i = 1; i <= 4; i++) begin
         if (req_o) reqCycles++;
         stepCycle();
      end
      if (req_o) reqCycles++;
      applyStimulus(1'b0, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 1'b0);
      checkOutput("ack_req_cycles", reqCycles, 5);
      checkOutput("ack_req_low", req_o, 1'b0);
      checkOutput("ack_busy_low", busy_o, 1'b0);
      checkOutput("ack_done", done_o, 1'b1);
      checkOutput("ack_no_timeout", timeout_o, 1'b0);
      checkOutput("ack_retry", retry_cnt_o, 0);
      checkOutput("ack_no_fault", fault_o, 1'b0);
      stepCycle();
      checkOutput("ack_done_pulse_end", done_o, 1'b0);

      // No acknowledge: three attempts, then fault
      applyStimulus(1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0);
      reqCycles = 0;
      timeouts  = 0;
      faultAt   = -1;
      bothCount = 0;
      for (int c = 0; c <= 70; c++) begin
         reqHist[c] = req_o;
         toHist[c]  = timeout_o;
         if (req_o) reqCycles++;
         if (timeout_o) timeouts++;
         if (done_o && timeout_o) bothCount++;
         if (fault_o) begin
            faultAt = c;
            break;
         end
         stepCycle();
      end
      checkOutput("noack_fault_at", faultAt, 50);
      checkOutput("noack_req_cycles", reqCycles, 48);
      checkOutput("noack_timeouts", timeouts, 3);
      checkOutput("noack_gap_req_low", reqHist[16], 1'b0);
      checkOutput("noack_gap_timeout", toHist[16], 1'b1);
      checkOutput("noack_req_rise", reqHist[17], 1'b1);
      checkOutput("noack_timeout_pulse_end", toHist[17], 1'b0);
      checkOutput("noack_retry", retry_cnt_o, 2);
      checkOutput("noack_busy", busy_o, 1'b0);
      checkOutput("noack_req", req_o, 1'b0);
      checkOutput("noack_final_timeout", timeout_o, 1'b1);
      stepCycle();
      stepCycle();
      checkOutput("fault_sticky", fault_o, 1'b1);
      checkOutput("fault_no_timeout", timeout_o, 1'b0);

      // Restart from FAULT
      applyStimulus(1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0);
      checkOutput("restart_fault_clr", fault_o, 1'b0);
      checkOutput("restart_retry", retry_cnt_o, 0);
      checkOutput("restart_req", req_o, 1'b1);
      checkOutput("restart_busy", busy_o, 1'b1);

      // Ignored start in REQ, ignored ack in GAP, acknowledge at counter boundary
      reqCycles = 0;
      timeouts  = 0;
      doneEarly = 0;
      for (int c = 0; c <= 32; c++) begin
         if (req_o) reqCycles++;
         if (timeout_o) timeouts++;
         if (done_o) doneEarly++;
         if (done_o && timeout_o) bothCount++;
         if (c == 16) begin
            checkOutput("gap_timeout", timeout_o, 1'b1);
            checkOutput("gap_req_low", req_o, 1'b0);
            checkOutput("gap_retry", retry_cnt_o, 1);
         end
         if (c == 17) checkOutput("gap_ack_ignored_req", req_o, 1'b1);
         applyStimulus(c == 5, c == 16 || c == 32);
         stepCycle();
      end
      applyStimulus(1'b0, 1'b0);
      checkOutput("bound_req_cycles", reqCycles, 32);
      checkOutput("bound_timeouts_before", timeouts, 1);
      checkOutput("bound_done_early", doneEarly, 0);
      checkOutput("bound_done", done_o, 1'b1);
      checkOutput("bound_no_timeout", timeout_o, 1'b0);
      checkOutput("bound_retry", retry_cnt_o, 1);
      checkOutput("bound_req_low", req_o, 1'b0);
      checkOutput("bound_busy_low", busy_o, 1'b0);
      checkOutput("bound_no_fault", fault_o, 1'b0);
      checkOutput("done_timeout_exclusive", bothCount, 0);
      stepCycle();
      checkOutput("bound_done_pulse_end", done_o, 1'b0);

      // Asynchronous reset during the 7th request cycle
      applyStimulus(1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0);
      repeat (6) stepCycle();
      checkOutput("mid_req_before_reset", req_o, 1'b1);
      #2;
      rst_i = 1'b1;
      #1;
      checkOutput("async_req", req_o, 1'b0);
      checkOutput("async_busy", busy_o, 1'b0);
      checkOutput("async_done", done_o, 1'b0);
      checkOutput("async_timeout", timeout_o, 1'b0);
      checkOutput("async_fault", fault_o, 1'b0);
      stepCycle();
      rst_i = 1'b0;
      stepCycle();
      checkOutput("post_reset_req", req_o, 1'b0);
      checkOutput("post_reset_busy", busy_o, 1'b0);
      checkOutput("post_reset_retry", retry_cnt_o, 0);
      applyStimulus(1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0);
      checkOutput("post_reset_start", req_o, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
